// File: rtl/cache_controller_if.sv
// Bus bundle for the cache controller: processor, data-RAM and main-memory sides.
// The controller connects through the slave modport; the environment uses master.
interface cache_controller_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int CACHE_ADDR_SIZE = 10,
    parameter int MAIN_ADDR_SIZE  = 16
);
    logic [MAIN_ADDR_SIZE-1:0]  ProcAddress;
    logic [DATA_WIDTH-1:0]      ProcDataIn;
    logic                       ProcRead;
    logic                       ProcWrite;
    logic [DATA_WIDTH-1:0]      ProcDataOut;
    logic                       ProcReady;

    logic [CACHE_ADDR_SIZE-1:0] CacheAddress;
    logic [DATA_WIDTH-1:0]      CacheDataIn;
    logic                       CacheWrite;
    logic [DATA_WIDTH-1:0]      CacheDataOut;

    logic [MAIN_ADDR_SIZE-1:0]  MemAddress;
    logic [DATA_WIDTH-1:0]      MemDataOut;
    logic                       MemRead;
    logic                       MemWrite;
    logic [DATA_WIDTH-1:0]      MemDataIn;
    logic                       MemReady;

    modport slave (
        input  ProcAddress, ProcDataIn, ProcRead, ProcWrite, CacheDataOut, MemDataIn, MemReady,
        output ProcDataOut, ProcReady, CacheAddress, CacheDataIn, CacheWrite,
               MemAddress, MemDataOut, MemRead, MemWrite
    );

    modport master (
        output ProcAddress, ProcDataIn, ProcRead, ProcWrite, CacheDataOut, MemDataIn, MemReady,
        input  ProcDataOut, ProcReady, CacheAddress, CacheDataIn, CacheWrite,
               MemAddress, MemDataOut, MemRead, MemWrite
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Tags and valid bits live here; data words live in an external RAM that samples
// CacheAddress on the falling edge. All bus outputs are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a processor request; latch it and present index
// COMPARE   | data RAM read settles; tag compare, dispatch hit/miss/write
// MEM_WRITE | write-through to main memory, wait for MemReady
// MEM_READ  | read miss, fetch word from main memory, wait for MemReady
// FILL      | write fetched word into data RAM, update tag/valid
module cache_controller #(
    parameter int DATA_WIDTH      = 8,
    parameter int CACHE_ADDR_SIZE = 10,
    parameter int MAIN_ADDR_SIZE  = 16
) (
    input logic               Clk,
    input logic               Reset,
    cache_controller_if.slave bus
);
    localparam int TAG_WIDTH = MAIN_ADDR_SIZE - CACHE_ADDR_SIZE;
    localparam int LINES     = 2 ** CACHE_ADDR_SIZE;

    typedef enum logic [2:0] {IDLE, COMPARE, MEM_WRITE, MEM_READ, FILL} state_t;

    state_t                      state_q, state_d;
    logic [MAIN_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        write_q, write_d;

    logic [DATA_WIDTH-1:0]       proc_data_out_q, proc_data_out_d;
    logic                        proc_ready_q, proc_ready_d;
    logic [CACHE_ADDR_SIZE-1:0]  cache_address_q, cache_address_d;
    logic [DATA_WIDTH-1:0]       cache_data_in_q, cache_data_in_d;
    logic                        cache_write_q, cache_write_d;
    logic [MAIN_ADDR_SIZE-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]       mem_data_out_q, mem_data_out_d;
    logic                        mem_read_q, mem_read_d;
    logic                        mem_write_q, mem_write_d;

    logic [TAG_WIDTH-1:0]        tag_q [LINES];
    logic [LINES-1:0]            valid_q;

    logic [CACHE_ADDR_SIZE-1:0]  index;
    logic [TAG_WIDTH-1:0]        tag;
    logic                        hit;
    logic                        accept;

    assign index = addr_q[CACHE_ADDR_SIZE-1:0];
    assign tag   = addr_q[MAIN_ADDR_SIZE-1:CACHE_ADDR_SIZE];
    assign hit   = valid_q[index] && (tag_q[index] == tag);

    // The processor still holds its request during the ProcReady cycle; that
    // request belongs to the transaction just finished, so it is not re-accepted.
    assign accept = (state_q == IDLE) && !proc_ready_q && (bus.ProcRead || bus.ProcWrite);

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            write_q         <= 1'b0;
            proc_data_out_q <= '0;
            proc_ready_q    <= 1'b0;
            cache_address_q <= '0;
            cache_data_in_q <= '0;
            cache_write_q   <= 1'b0;
            mem_address_q   <= '0;
            mem_data_out_q  <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            write_q         <= write_d;
            proc_data_out_q <= proc_data_out_d;
            proc_ready_q    <= proc_ready_d;
            cache_address_q <= cache_address_d;
            cache_data_in_q <= cache_data_in_d;
            cache_write_q   <= cache_write_d;
            mem_address_q   <= mem_address_d;
            mem_data_out_q  <= mem_data_out_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
        end
    end

    // Valid bits: cleared by reset, set when a fill completes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= '0;
        end else if (state_q == FILL) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag array needs no reset; it is only meaningful where valid is set
    always_ff @(posedge Clk) begin
        if (!Reset && state_q == FILL) begin
            tag_q[index] <= tag;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = COMPARE;
            COMPARE:   state_d = write_q ? MEM_WRITE : (hit ? IDLE : MEM_READ);
            MEM_READ:  if (bus.MemReady) state_d = FILL;
            MEM_WRITE: if (bus.MemReady) state_d = IDLE;
            FILL:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the latched request and all registered outputs
    always_comb begin
        addr_d          = addr_q;
        data_d          = data_q;
        write_d         = write_q;
        proc_data_out_d = proc_data_out_q;
        proc_ready_d    = 1'b0;
        cache_address_d = cache_address_q;
        cache_data_in_d = cache_data_in_q;
        cache_write_d   = 1'b0;
        mem_address_d   = mem_address_q;
        mem_data_out_d  = mem_data_out_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d          = bus.ProcAddress;
                    data_d          = bus.ProcDataIn;
                    write_d         = bus.ProcWrite;
                    cache_address_d = bus.ProcAddress[CACHE_ADDR_SIZE-1:0];
                end
            end
            COMPARE: begin
                if (write_q) begin
                    mem_write_d    = 1'b1;
                    mem_address_d  = addr_q;
                    mem_data_out_d = data_q;
                    if (hit) begin
                        cache_write_d   = 1'b1;
                        cache_data_in_d = data_q;
                    end
                end else if (hit) begin
                    proc_ready_d    = 1'b1;
                    proc_data_out_d = bus.CacheDataOut;
                end else begin
                    mem_read_d    = 1'b1;
                    mem_address_d = addr_q;
                end
            end
            MEM_READ: begin
                if (bus.MemReady) begin
                    mem_read_d      = 1'b0;
                    cache_write_d   = 1'b1;
                    cache_data_in_d = bus.MemDataIn;
                    proc_data_out_d = bus.MemDataIn;
                    proc_ready_d    = 1'b1;
                end
            end
            MEM_WRITE: begin
                if (bus.MemReady) begin
                    mem_write_d  = 1'b0;
                    proc_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ProcDataOut  = proc_data_out_q;
    assign bus.ProcReady    = proc_ready_q;
    assign bus.CacheAddress = cache_address_q;
    assign bus.CacheDataIn  = cache_data_in_q;
    assign bus.CacheWrite   = cache_write_q;
    assign bus.MemAddress   = mem_address_q;
    assign bus.MemDataOut   = mem_data_out_q;
    assign bus.MemRead      = mem_read_q;
    assign bus.MemWrite     = mem_write_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a negedge-sampling data RAM model
// and a fixed-latency main-memory responder.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_controller_if bus ();
    cache_controller dut (.Clk(clk), .Reset(rst), .bus(bus));

    logic [7:0] ram [0:1023];

    // Data RAM: samples address and write data on the falling edge
    always @(negedge clk) begin
        if (bus.CacheWrite) ram[bus.CacheAddress] = bus.CacheDataIn;
        bus.CacheDataOut = ram[bus.CacheAddress];
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    int          rdy_cyc, mr_cyc, mw_cyc, cw_cnt;
    logic [9:0]  cw_addr;
    logic [7:0]  cw_data, rd_data, mw_data;
    logic [15:0] mem_addr_seen;

    // One processor transaction; memory answers after 'lat' busy cycles.
    // Request is driven at a negedge, observations are taken at negedges.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input int lat, input logic [7:0] mdata);
        int busy;
        busy = 0;
        rdy_cyc = -1; mr_cyc = 0; mw_cyc = 0; cw_cnt = 0;
        cw_addr = '0; cw_data = '0; rd_data = '0; mw_data = '0; mem_addr_seen = '0;
        @(negedge clk);
        bus.ProcAddress = a;
        bus.ProcDataIn  = d;
        bus.ProcRead    = rd;
        bus.ProcWrite   = wr;
        bus.MemDataIn   = mdata;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.MemReady = 1'b0;
            if (bus.MemRead) begin mr_cyc++; mem_addr_seen = bus.MemAddress; end
            if (bus.MemWrite) begin
                mw_cyc++; mem_addr_seen = bus.MemAddress; mw_data = bus.MemDataOut;
            end
            if (bus.CacheWrite) begin
                cw_cnt++; cw_addr = bus.CacheAddress; cw_data = bus.CacheDataIn;
            end
            if (bus.ProcReady) begin
                rdy_cyc = c; rd_data = bus.ProcDataOut;
                break;
            end
            if (bus.MemRead || bus.MemWrite) begin
                busy++;
                if (busy == lat) bus.MemReady = 1'b1;
            end
        end
        bus.ProcRead  = 1'b0;
        bus.ProcWrite = 1'b0;
        bus.MemReady  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ProcAddress = '0; bus.ProcDataIn = '0; bus.ProcRead = 0; bus.ProcWrite = 0;
        bus.MemDataIn = '0; bus.MemReady = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({bus.ProcReady, bus.CacheWrite, bus.MemRead, bus.MemWrite} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus.ProcReady, bus.CacheWrite, bus.MemRead, bus.MemWrite});
        else pass_cnt++;
        total_cnt++;
        if ({bus.ProcDataOut, bus.CacheAddress, bus.CacheDataIn, bus.MemAddress, bus.MemDataOut} !== '0)
            $display("FAIL reset_data: dout=%h caddr=%h cdin=%h maddr=%h mdout=%h want all 0",
                     bus.ProcDataOut, bus.CacheAddress, bus.CacheDataIn, bus.MemAddress, bus.MemDataOut);
        else pass_cnt++;
    endtask

    // Miss with latency L: COMPARE, L cycles of MEM_READ, then FILL -> ready at L+2
    task automatic test_cold_read();
        run_txn(1, 0, 16'h0123, 8'h00, 3, 8'h5A);
        total_cnt++;
        if (mr_cyc !== 3) $display("FAIL cold_memread_cycles: got %0d want 3", mr_cyc); else pass_cnt++;
        total_cnt++;
        if (mem_addr_seen !== 16'h0123) $display("FAIL cold_memaddr: got %h want 0123", mem_addr_seen); else pass_cnt++;
        total_cnt++;
        if (cw_cnt !== 1 || cw_addr !== 10'h123 || cw_data !== 8'h5A)
            $display("FAIL cold_fill: cnt=%0d addr=%h data=%h want 1/123/5a", cw_cnt, cw_addr, cw_data);
        else pass_cnt++;
        total_cnt++;
        if (rdy_cyc !== 5 || rd_data !== 8'h5A)
            $display("FAIL cold_ready: cyc=%0d data=%h want 5/5a", rdy_cyc, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_read_hit();
        run_txn(1, 0, 16'h0123, 8'h00, 3, 8'hFF);
        total_cnt++;
        if (rdy_cyc !== 2 || rd_data !== 8'h5A)
            $display("FAIL hit_ready: cyc=%0d data=%h want 2/5a", rdy_cyc, rd_data);
        else pass_cnt++;
        total_cnt++;
        if (mr_cyc !== 0 || cw_cnt !== 0)
            $display("FAIL hit_no_mem: memread=%0d cachewrite=%0d want 0/0", mr_cyc, cw_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.ProcReady !== 1'b0 || bus.ProcDataOut !== 8'h5A)
            $display("FAIL hit_hold: ready=%b dout=%h want 0/5a", bus.ProcReady, bus.ProcDataOut);
        else pass_cnt++;
    endtask

    task automatic test_conflict_miss();
        run_txn(1, 0, 16'h0523, 8'h00, 2, 8'h77);
        total_cnt++;
        if (mr_cyc !== 2 || cw_addr !== 10'h123 || cw_data !== 8'h77 || rd_data !== 8'h77)
            $display("FAIL conflict_refill: mr=%0d caddr=%h cdata=%h dout=%h want 2/123/77/77",
                     mr_cyc, cw_addr, cw_data, rd_data);
        else pass_cnt++;
        run_txn(1, 0, 16'h0123, 8'h00, 1, 8'h5A);
        total_cnt++;
        if (mr_cyc !== 1 || rdy_cyc !== 3 || rd_data !== 8'h5A)
            $display("FAIL conflict_reread_miss: mr=%0d cyc=%0d dout=%h want 1/3/5a", mr_cyc, rdy_cyc, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_write_hit_miss();
        run_txn(0, 1, 16'h0123, 8'hC3, 2, 8'h00);
        total_cnt++;
        if (mw_cyc !== 2 || mem_addr_seen !== 16'h0123 || mw_data !== 8'hC3 || rdy_cyc !== 4)
            $display("FAIL whit_mem: mw=%0d addr=%h data=%h cyc=%0d want 2/0123/c3/4",
                     mw_cyc, mem_addr_seen, mw_data, rdy_cyc);
        else pass_cnt++;
        total_cnt++;
        if (cw_cnt !== 1 || cw_addr !== 10'h123 || cw_data !== 8'hC3)
            $display("FAIL whit_cache: cnt=%0d addr=%h data=%h want 1/123/c3", cw_cnt, cw_addr, cw_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.ProcDataOut !== 8'h5A)
            $display("FAIL whit_dout_hold: got %h want 5a", bus.ProcDataOut);
        else pass_cnt++;
        run_txn(1, 0, 16'h0123, 8'h00, 2, 8'hEE);
        total_cnt++;
        if (mr_cyc !== 0 || rdy_cyc !== 2 || rd_data !== 8'hC3)
            $display("FAIL whit_readback: mr=%0d cyc=%0d dout=%h want 0/2/c3", mr_cyc, rdy_cyc, rd_data);
        else pass_cnt++;
        run_txn(0, 1, 16'h0200, 8'h99, 1, 8'h00);
        total_cnt++;
        if (mw_cyc !== 1 || mw_data !== 8'h99 || cw_cnt !== 0 || rdy_cyc !== 3)
            $display("FAIL wmiss: mw=%0d data=%h cw=%0d cyc=%0d want 1/99/0/3", mw_cyc, mw_data, cw_cnt, rdy_cyc);
        else pass_cnt++;
        run_txn(1, 0, 16'h0200, 8'h00, 2, 8'h11);
        total_cnt++;
        if (mr_cyc !== 2 || rd_data !== 8'h11)
            $display("FAIL wmiss_readback: mr=%0d dout=%h want 2/11", mr_cyc, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_miss();
        int seen, bad;
        seen = 0; bad = 0;
        @(negedge clk);
        bus.ProcAddress = 16'h0345; bus.ProcRead = 1'b1; bus.MemDataIn = 8'hEE;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.MemRead) begin seen = 1; break; end
        end
        total_cnt++;
        if (seen !== 1) $display("FAIL rmid_memread_seen: got %0d want 1", seen); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ProcRead = 1'b0;
        bus.MemReady = 1'b1;
        @(negedge clk);
        bus.MemReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.ProcReady || bus.CacheWrite || bus.MemRead || bus.MemWrite) bad++;
            @(negedge clk);
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL rmid_quiet: got %0d active cycles want 0", bad); else pass_cnt++;
        run_txn(1, 0, 16'h0345, 8'h00, 1, 8'hEE);
        total_cnt++;
        if (mr_cyc !== 1 || rd_data !== 8'hEE)
            $display("FAIL rmid_remiss: mr=%0d dout=%h want 1/ee", mr_cyc, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_read_write_priority();
        run_txn(1, 1, 16'h0123, 8'h3C, 2, 8'h44);
        total_cnt++;
        if (mw_cyc !== 2 || mr_cyc !== 0 || mw_data !== 8'h3C)
            $display("FAIL rw_priority: mw=%0d mr=%0d data=%h want 2/0/3c", mw_cyc, mr_cyc, mw_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_conflict_miss();
        test_write_hit_miss();
        test_reset_mid_miss();
        test_read_write_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
